mfp_adc_max10_scanner: RTL and testbench

Autonomous scan sequencer between `mfp_system` and the MAX10 `adc` IP on DE10-Lite.
- Walks an enabled-channel mask and issues one single-beat command per channel on the ADC command stream.
- Matches each response to its command and stores the 12-bit result per channel.
- Exposes results through a registered read port for the system's memory-mapped ADC peripheral.
- Removes per-conversion software handshaking and adds a response watchdog.

---
 rtl/mfp_adc_max10_scanner.sv | 185 ++++++++++++++++++
 tb/tb_mfp_adc_max10_scanner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_adc_max10_scanner.sv
// rtl/mfp_adc_max10_scanner.sv - MAX10 ADC scan sequencer with per-channel result store and response watchdog
// Optional macro MFP_ADC_SCANNER_IRQ_EN adds a scan-complete interrupt (irq/irq_ack).
module mfp_adc_max10_scanner #(
    parameter int N_CHANNELS = 9,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [N_CHANNELS-1:0] channel_mask,
    output logic                  ADC_C_Valid,
    output logic [4:0]            ADC_C_Channel,
    output logic                  ADC_C_SOP,
    output logic                  ADC_C_EOP,
    input  logic                  ADC_C_Ready,
    input  logic                  ADC_R_Valid,
    input  logic [4:0]            ADC_R_Channel,
    input  logic [11:0]           ADC_R_Data,
    input  logic                  ADC_R_SOP,
    input  logic                  ADC_R_EOP,
    input  logic                  rd_en,
    input  logic [4:0]            rd_index,
    output logic [11:0]           rd_data,
    output logic                  rd_fresh,
    output logic [15:0]           scan_count,
    output logic                  timeout_err,
`ifdef MFP_ADC_SCANNER_IRQ_EN
    output logic                  irq,
    input  logic                  irq_ack,
`endif
    input  logic                  err_clr
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_CMD, S_WAIT} state_t;

    state_t                  state_q;
    logic [4:0]              ptr_q;
    logic [4:0]              cur_q;
    logic                    last_q;
    logic                    valid_q;
    logic [WD_W-1:0]         wd_q;
    logic [11:0]             result_q [N_CHANNELS];
    logic [N_CHANNELS-1:0]   fresh_q;
    logic [11:0]             rd_data_q;
    logic                    rd_fresh_q;
    logic [15:0]             scan_q;
    logic                    err_q;
    logic                    irq_q;

    logic [4:0] lo_any, lo_above, hi_any;
    logic       above_found;
    logic [4:0] sel_cur_d;
    logic       sel_last_d;
    logic       rsp_match, wd_fire, conv_done, scan_done;
    logic       unused_ok;

    assign unused_ok = ADC_R_SOP ^ ADC_R_EOP;

    // Round-robin pick: lowest enabled channel at/above ptr, else wrap to lowest enabled.
    always_comb begin
        lo_any      = '0;
        lo_above    = '0;
        hi_any      = '0;
        above_found = 1'b0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (channel_mask[i]) begin
                lo_any = 5'(i);
                if (5'(i) >= ptr_q) begin
                    lo_above    = 5'(i);
                    above_found = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (channel_mask[i]) hi_any = 5'(i);
        end
        sel_cur_d  = above_found ? lo_above : lo_any;
        sel_last_d = (sel_cur_d == hi_any);
    end

    // A matching response takes priority over a watchdog expiry on the same edge.
    assign rsp_match = (state_q == S_WAIT) && ADC_R_Valid && (ADC_R_Channel == cur_q);
    assign wd_fire   = (state_q == S_WAIT) && !rsp_match && (wd_q == WD_LAST);
    assign conv_done = rsp_match || wd_fire;
    assign scan_done = conv_done && last_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            wd_q       <= '0;
            fresh_q    <= '0;
            rd_data_q  <= '0;
            rd_fresh_q <= 1'b0;
            scan_q     <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) result_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && (channel_mask != '0)) state_q <= S_SELECT;
                end
                S_SELECT: begin
                    if (channel_mask == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cur_q   <= sel_cur_d;
                        last_q  <= sel_last_d;
                        valid_q <= 1'b1;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (ADC_C_Ready) begin
                        valid_q <= 1'b0;
                        wd_q    <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (conv_done) begin
                        ptr_q   <= last_q ? 5'd0 : cur_q + 5'd1;
                        state_q <= enable ? S_SELECT : S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (scan_done) scan_q <= scan_q + 16'd1;

            if (wd_fire)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;

            if (scan_done) irq_q <= 1'b1;
`ifdef MFP_ADC_SCANNER_IRQ_EN
            else if (irq_ack) irq_q <= 1'b0;
`endif

            // Read returns the pre-store value; a same-cycle store keeps the slot fresh.
            if (rd_en) begin
                rd_data_q  <= '0;
                rd_fresh_q <= 1'b0;
                for (int i = 0; i < N_CHANNELS; i++) begin
                    if (rd_index == 5'(i)) begin
                        rd_data_q  <= result_q[i];
                        rd_fresh_q <= fresh_q[i];
                    end
                end
            end

            for (int i = 0; i < N_CHANNELS; i++) begin
                if (rsp_match && (cur_q == 5'(i))) begin
                    result_q[i] <= ADC_R_Data;
                    fresh_q[i]  <= 1'b1;
                end else if (rd_en && (rd_index == 5'(i))) begin
                    fresh_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign ADC_C_Valid   = valid_q;
    assign ADC_C_SOP     = valid_q;
    assign ADC_C_EOP     = valid_q;
    assign ADC_C_Channel = cur_q;
    assign rd_data       = rd_data_q;
    assign rd_fresh      = rd_fresh_q;
    assign scan_count    = scan_q;
    assign timeout_err   = err_q;
`ifdef MFP_ADC_SCANNER_IRQ_EN
    assign irq           = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_mfp_adc_max10_scanner.sv
// tb/tb_mfp_adc_max10_scanner.sv - directed bench with transaction-level scoreboard for mfp_adc_max10_scanner
module tb_mfp_adc_max10_scanner;
    localparam int N  = 9;
    localparam int TO = 1023;

    logic         clk = 1'b0;
    logic         resetn, enable;
    logic [N-1:0] channel_mask;
    logic         ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
    logic [4:0]   ADC_C_Channel;
    logic         ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
    logic [4:0]   ADC_R_Channel;
    logic [11:0]  ADC_R_Data;
    logic         rd_en;
    logic [4:0]   rd_index;
    logic [11:0]  rd_data;
    logic         rd_fresh;
    logic [15:0]  scan_count;
    logic         timeout_err, err_clr;
`ifdef MFP_ADC_SCANNER_IRQ_EN
    logic         irq, irq_ack;
`endif

    mfp_adc_max10_scanner #(.N_CHANNELS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .channel_mask(channel_mask),
        .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
        .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
        .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
        .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
        .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_fresh(rd_fresh),
        .scan_count(scan_count), .timeout_err(timeout_err),
`ifdef MFP_ADC_SCANNER_IRQ_EN
        .irq(irq), .irq_ack(irq_ack),
`endif
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int next_ch(input int prev, input logic [N-1:0] m);
        for (int i = prev + 1; i < N; i++) if (m[i]) return i;
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int top_ch(input logic [N-1:0] m);
        int t = 0;
        for (int i = 0; i < N; i++) if (m[i]) t = i;
        return t;
    endfunction

    // Scoreboard: conversion-level view of what the scanner must have done
    int  m_res [N];
    bit  m_fresh [N];
    int  m_scan, m_cur, m_prev, m_age, m_rd_data;
    bit  m_err, m_pend, m_idle, m_hold, m_last, m_rd_fresh, m_irq, m_done;

    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin m_res[i] = 0; m_fresh[i] = 0; end
            m_scan = 0; m_err = 0; m_prev = -1; m_pend = 0; m_age = 0;
            m_rd_data = 0; m_rd_fresh = 0; m_irq = 0; m_idle = 1; m_hold = 0;
        end else begin
            m_done = 0;
            m_hold = ADC_C_Valid && !ADC_C_Ready;
            if (rd_en) begin
                if (int'(rd_index) < N) begin
                    m_rd_data  = m_res[rd_index];
                    m_rd_fresh = m_fresh[rd_index];
                    m_fresh[rd_index] = 0;
                end else begin
                    m_rd_data = 0; m_rd_fresh = 0;
                end
            end
            if (err_clr) m_err = 0;
`ifdef MFP_ADC_SCANNER_IRQ_EN
            if (irq_ack) m_irq = 0;
`endif
            if (m_pend) begin
                m_age++;
                if (ADC_R_Valid && int'(ADC_R_Channel) == m_cur) begin
                    m_res[m_cur] = ADC_R_Data; m_fresh[m_cur] = 1; m_done = 1;
                end else if (m_age == TO) begin
                    m_err = 1; m_done = 1;
                end
                if (m_done) begin
                    m_pend = 0;
                    if (m_last) begin m_scan++; m_irq = 1; m_prev = -1; end
                    else m_prev = m_cur;
                    if (!enable) m_idle = 1;
                end
            end else if (ADC_C_Valid && ADC_C_Ready) begin
                m_cur  = next_ch(m_prev, channel_mask);
                m_last = (top_ch(channel_mask) == m_cur);
                m_pend = 1; m_age = 0;
            end
            if (m_idle && !m_done && enable && channel_mask != '0) m_idle = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("scan_count", scan_count, m_scan & 16'hffff);
        chk("timeout_err", timeout_err, m_err);
        chk("rd_data", rd_data, m_rd_data);
        chk("rd_fresh", rd_fresh, m_rd_fresh);
        chk("sop", ADC_C_SOP, ADC_C_Valid);
        chk("eop", ADC_C_EOP, ADC_C_Valid);
`ifdef MFP_ADC_SCANNER_IRQ_EN
        chk("irq", irq, m_irq);
`endif
        if (m_hold) chk("valid_hold", ADC_C_Valid, 1);
        if (m_pend || m_idle) chk("valid_quiet", ADC_C_Valid, 0);
        if (ADC_C_Valid) chk("cmd_channel", ADC_C_Channel, next_ch(m_prev, channel_mask));
    end

    // ADC model and per-cycle input driving, all at the falling edge
    int         ready_delay = 2, rsp_delay = 20, no_rsp_ch = -1;
    bit         rsp_auto = 1, rsp_wait = 0, man_valid = 0;
    int         vcnt = 0, rsp_cnt = 0, rsp_ch = 0, cyc = 0, acc_cyc = 0, man_ch = 0;
    logic [11:0] man_data = '0;
    int         acc_q [$];

    task automatic step();
        @(negedge clk);
        cyc++;
        ADC_R_Valid = 0; rd_en = 0; err_clr = 0;
`ifdef MFP_ADC_SCANNER_IRQ_EN
        irq_ack = 0;
`endif
        if (!resetn) begin
            ADC_C_Ready = 0; vcnt = 0; rsp_wait = 0;
        end else begin
            if (ADC_C_Ready) begin
                ADC_C_Ready = 0; vcnt = 0;
                acc_q.push_back(int'(ADC_C_Channel)); acc_cyc = cyc;
                if (rsp_auto && int'(ADC_C_Channel) != no_rsp_ch) begin
                    rsp_wait = 1; rsp_cnt = 0; rsp_ch = int'(ADC_C_Channel);
                end
            end else if (ADC_C_Valid) begin
                vcnt++;
                if (vcnt >= ready_delay) ADC_C_Ready = 1;
            end
            if (rsp_wait) begin
                rsp_cnt++;
                if (rsp_cnt >= rsp_delay) begin
                    ADC_R_Valid = 1; ADC_R_Channel = 5'(rsp_ch);
                    ADC_R_Data = 12'(32'h100 + rsp_ch); rsp_wait = 0;
                end
            end
        end
        if (man_valid) begin
            ADC_R_Valid = 1; ADC_R_Channel = 5'(man_ch); ADC_R_Data = man_data; man_valid = 0;
        end
    endtask

    task automatic do_read(input int idx);
        rd_en = 1; rd_index = 5'(idx);
        step();
    endtask

    task automatic wait_accept(input string name);
        int n0 = acc_q.size();
        int n = 0;
        while (acc_q.size() == n0 && n < 100) begin step(); n++; end
        chk(name, acc_q.size(), n0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n, n0, s0;
        resetn = 0; enable = 0; channel_mask = '0; ADC_C_Ready = 0;
        ADC_R_Valid = 0; ADC_R_Channel = '0; ADC_R_Data = '0; ADC_R_SOP = 0; ADC_R_EOP = 0;
        rd_en = 0; rd_index = '0; err_clr = 0;
`ifdef MFP_ADC_SCANNER_IRQ_EN
        irq_ack = 0;
`endif
        repeat (3) step();
        resetn = 1;
        step();
        chk("rst_valid", ADC_C_Valid, 0);
        chk("rst_channel", ADC_C_Channel, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_scan", scan_count, 0);
        chk("rst_err", timeout_err, 0);

        // Two-channel scan with ready after 2 cycles, response after 20
        channel_mask = 9'b0_0000_0110; enable = 1;
        step(); chk("valid_edge_k1", ADC_C_Valid, 0);
        step(); chk("valid_edge_k2", ADC_C_Valid, 1);
        chk("first_channel", ADC_C_Channel, 1);
        n = 0;
        while (scan_count != 16'd2 && n < 500) begin step(); n++; end
        chk("two_scans", scan_count, 2);
        chk("cmd_count", acc_q.size(), 4);
        if (acc_q.size() >= 4) begin
            chk("order0", acc_q[0], 1); chk("order1", acc_q[1], 2);
            chk("order2", acc_q[2], 1); chk("order3", acc_q[3], 2);
        end
        do_read(2); chk("read2_data", rd_data, 12'h102); chk("read2_fresh", rd_fresh, 1);
        do_read(2); chk("reread2_data", rd_data, 12'h102); chk("reread2_fresh", rd_fresh, 0);
        do_read(20); chk("oob_data", rd_data, 0); chk("oob_fresh", rd_fresh, 0);
        do_read(1); chk("read1_data", rd_data, 12'h101);
        enable = 0;
        repeat (60) step();
        chk("idle_after_scan", ADC_C_Valid, 0);

        // Ready stalled for 50 cycles, enable dropped during the stall
        ready_delay = 50; n0 = acc_q.size(); enable = 1;
        n = 0;
        while (!ADC_C_Valid && n < 20) begin step(); n++; end
        repeat (20) step();
        chk("stall_valid", ADC_C_Valid, 1);
        enable = 0;
        repeat (150) step();
        chk("stall_one_cmd", acc_q.size(), n0 + 1);
        chk("stall_idle", ADC_C_Valid, 0);

        // Channel 3 never answers
        ready_delay = 1; channel_mask = 9'b0_0001_1000; no_rsp_ch = 3; enable = 1;
        n = 0;
        while (!timeout_err && n < 3000) begin step(); n++; end
        chk("wd_fired", timeout_err, 1);
        chk("wd_channel", acc_q.size() > 0 ? acc_q[$] : -1, 3);
        chk("wd_latency", cyc - acc_cyc, TO);
        wait_accept("after_wd_accept");
        enable = 0;
        chk("after_wd_channel", acc_q.size() > 0 ? acc_q[$] : -1, 4);
        repeat (40) step();
        chk("err_sticky", timeout_err, 1);
        err_clr = 1; step(); step();
        chk("err_cleared", timeout_err, 0);

        // Stray response while waiting on channel 1
        no_rsp_ch = -1; rsp_auto = 0; channel_mask = 9'b0_0000_0010; enable = 1;
        wait_accept("stray_accept");
        enable = 0;
        s0 = int'(scan_count);
        man_ch = 5; man_data = 12'habc; man_valid = 1;
        repeat (6) step();
        chk("stray_no_scan", scan_count, s0);
        man_ch = 1; man_data = 12'h055; man_valid = 1;
        step(); step();
        chk("stray_then_match", scan_count, s0 + 1);
        do_read(5); chk("slot5_data", rd_data, 0); chk("slot5_fresh", rd_fresh, 0);
        do_read(1); chk("slot1_data", rd_data, 12'h055); chk("slot1_fresh", rd_fresh, 1);

        // Reset while a conversion is outstanding, late response after release
        enable = 1;
        wait_accept("rst_accept");
        enable = 0;
        repeat (3) step();
        resetn = 0; step(); step(); resetn = 1;
        step(); step();
        man_ch = 1; man_data = 12'h777; man_valid = 1;
        step(); step();
        chk("rst2_scan", scan_count, 0);
        chk("rst2_valid", ADC_C_Valid, 0);
        chk("rst2_rd_data", rd_data, 0);
        do_read(1); chk("rst2_slot1", rd_data, 0); chk("rst2_fresh", rd_fresh, 0);

`ifdef MFP_ADC_SCANNER_IRQ_EN
        // Single top channel: every conversion completes a scan
        rsp_auto = 1; ready_delay = 2; channel_mask = 9'b1_0000_0000; enable = 1;
        n = 0;
        while (scan_count != 16'd1 && n < 200) begin step(); n++; end
        chk("irq_scan1", scan_count, 1);
        chk("irq_set", irq, 1);
        n = 0;
        while (scan_count != 16'd2 && n < 200) begin step(); n++; end
        chk("irq_scan2", scan_count, 2);
        chk("irq_held", irq, 1);
        irq_ack = 1; step();
        chk("irq_acked", irq, 0);
        enable = 0;
        repeat (60) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
